// File: rtl/mips_cpu_pkg.sv
// Shared CPU definitions: ALU decoder control codes and HI/LO sequencer states.
package mips_cpu_pkg;

  localparam logic [4:0] ALU_MULTU = 5'b00111;
  localparam logic [4:0] ALU_MULT  = 5'b01000;
  localparam logic [4:0] ALU_DIV   = 5'b01111;
  localparam logic [4:0] ALU_DIVU  = 5'b10000;
  localparam logic [4:0] ALU_MTHI  = 5'b10001;
  localparam logic [4:0] ALU_MTLO  = 5'b10010;
  localparam logic [4:0] ALU_MFHI  = 5'b11010;
  localparam logic [4:0] ALU_MFLO  = 5'b11011;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX
  } hilo_state_t;

endpackage

// File: rtl/mips_cpu_hilo_step.sv
// One radix-2 iteration of unsigned shift-add multiply or restoring divide.
// Accumulator layout: {upper half (partial product / remainder), lower half (multiplier / quotient)}.
module mips_cpu_hilo_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  input  logic              is_div,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    rem_sh = acc[2*XLEN-1:XLEN-1];
    diff   = rem_sh - {1'b0, opnd};
    acc_next = {sum, acc[XLEN-1:1]};
    if (is_div) begin
      // Borrow out of the 33-bit subtract means the divisor did not fit.
      if (!diff[XLEN]) acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else             acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mips_cpu_hilo_unit.sv
// HI/LO resource: MTHI/MTLO in one cycle, MULT(U)/DIV(U) over 1 + ITER + 1 edges,
// stalling the main FSM for any HI/LO request that arrives while an iteration runs.
module mips_cpu_hilo_unit import mips_cpu_pkg::*; #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic            rd_req,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int            CW   = $clog2(ITER) + 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  hilo_state_t       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic              is_div_q, is_div_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              dz_q, dz_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d;

  logic              op_mul, op_div, op_signed;
  logic [XLEN-1:0]   a_mag, b_mag, quo, rem;
  logic [2*XLEN-1:0] prod;

  mips_cpu_hilo_step #(.XLEN(XLEN)) u_step (
    .acc      (acc_q),
    .opnd     (dvs_q),
    .is_div   (is_div_q),
    .acc_next (acc_step)
  );

  always_comb begin
    op_mul    = (op == ALU_MULT) || (op == ALU_MULTU);
    op_div    = (op == ALU_DIV)  || (op == ALU_DIVU);
    op_signed = (op == ALU_MULT) || (op == ALU_DIV);
    a_mag     = (op_signed && a[XLEN-1]) ? -a : a;
    b_mag     = (op_signed && b[XLEN-1]) ? -b : b;
    prod      = neg_quo_q ? -acc_q : acc_q;
    quo       = neg_quo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem       = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    dvs_d     = dvs_q;
    is_div_d  = is_div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (op == ALU_MTHI) begin
            hi_d = a;
          end else if (op == ALU_MTLO) begin
            lo_d = a;
          end else if (op_mul || op_div) begin
            state_d   = mips_cpu_pkg::ITER;
            cnt_d     = '0;
            dz_d      = op_div && (b == '0);
            // A zero divisor keeps the raw dividend parked so it can be returned as HI.
            acc_d     = {{XLEN{1'b0}}, (op_div && (b == '0)) ? a : a_mag};
            dvs_d     = b_mag;
            is_div_d  = op_div;
            neg_quo_d = op_signed && (a[XLEN-1] ^ b[XLEN-1]);
            neg_rem_d = op_signed && a[XLEN-1];
          end
        end
      end
      mips_cpu_pkg::ITER: begin
        if (!dz_q) acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod[2*XLEN-1:XLEN];
          lo_d = prod[XLEN-1:0];
        end else if (dz_q) begin
          lo_d = '1;
          hi_d = acc_q[XLEN-1:0];
        end else begin
          lo_d = quo;
          hi_d = rem;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      dvs_q     <= '0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      dvs_q     <= dvs_d;
      is_div_q  <= is_div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign stall = busy & (start | rd_req);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: doc/mips_cpu_hilo_unit.md
Name: mips_cpu_hilo_unit

Overview:
Multi-cycle HI/LO resource for the multicycle MIPS CPU: iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO writes and MFHI/MFLO reads.
- Receives the 5-bit alucontrol code already produced by the ALU decoder.
- Holds the architectural HI and LO registers.
- Asserts stall back to the main control FSM whenever a new HI/LO operation or read arrives while an iteration is still running.

Parameters:
- XLEN, 32, operand/HI/LO width.
- ITER, 32, iteration cycles for multiply and divide (must equal XLEN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request: execute op this cycle (main FSM execute state).
- op  in  5  alucontrol code: 00111 MULTU, 01000 MULT, 01111 DIV, 10000 DIVU, 10001 MTHI, 10010 MTLO; any other code is ignored.
- rd_req  in  1  main FSM is executing MFHI/MFLO (11010/11011) this cycle.
- a  in  32  rs operand.
- b  in  32  rt operand.
- busy  out  1  iteration in progress.
- stall  out  1  combinational: busy & (start | rd_req).
- done  out  1  one-cycle pulse on the cycle HI/LO first show a mul/div result.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (async, reset==0): state=IDLE; hi=0, lo=0, busy=0, done=0. Any in-flight iteration is discarded.
- States: IDLE, ITER, FIX.
- Accept rule: start is accepted only when state==IDLE. While busy, start is ignored, stall=1, and the main FSM holds op/a/b stable until stall falls.
- MTHI/MTLO in IDLE:
  - hi (or lo) <= a on the same edge.
  - No busy, no done.
  - The other register is unchanged.
- MULT/MULTU/DIV/DIVU accepted at edge E0:
  - IDLE->ITER. Latch |a|,|b| (signed ops; unsigned ops take raw values), sign_q=a[31]^b[31], sign_r=a[31]. Clear counter.
- ITER: one radix-2 step per cycle.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, remainder in upper half, quotient shifted into the lower half.
  - After ITER steps (edges E1..E32), go to FIX.
- FIX (edge E33): apply sign correction.
  - MULT: negate the 64-bit product if sign_q.
  - DIV: negate quotient if sign_q, negate remainder if sign_r.
  - Write hi/lo on this edge (mul: hi=prod[63:32], lo=prod[31:0]; div: lo=quotient, hi=remainder).
  - Then ->IDLE.
- Timing: busy=1 from after E0 through E33 (33 cycles). done=1 and new hi/lo visible in the cycle after E33; busy=0 in that same cycle.
- Divide by zero (b==0, signed or unsigned): runs the full latency. Result is fixed with sign correction bypassed: lo=32'hFFFF_FFFF, hi=a.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap of the magnitude path).
- rd_req while busy: stall=1 until busy falls. hi/lo stay at old values until the FIX edge.
- rd_req while IDLE: stall=0; hi/lo are read combinationally by the datapath.
- Simultaneous start and rd_req in IDLE: the start is processed; stall=0.
- Reset mid-ITER: immediate abort to IDLE; hi=lo=0.
- Unknown op with start=1: no state change, no stall.

Decomposition:
- Shared package mips_cpu_pkg holds:
  - localparams for the alucontrol codes above (ALU_MULTU, ALU_MULT, ALU_DIV, ALU_DIVU, ALU_MTHI, ALU_MTLO, ALU_MFHI, ALU_MFLO);
  - the state enum hilo_state_t {IDLE, ITER, FIX}.
- The ALU decoder moves to the same code localparams.
- One combinational sub-module, mips_cpu_hilo_step:
  - inputs: 64-bit accumulator, 32-bit operand, is_div;
  - output: next accumulator for one iteration.
  - It keeps the shift-add and shift-subtract logic out of the FSM.

Test Plan:
- MULTU a=FFFFFFFF b=FFFFFFFF -> busy for 33 cycles; done; hi=FFFFFFFE lo=00000001.
- MULT a=FFFFFFFD(-3) b=00000007 -> hi=FFFFFFFF lo=FFFFFFEB; DIV a=FFFFFFF9(-7) b=2 -> lo=FFFFFFFD hi=FFFFFFFF.
- DIVU a=100 b=7 -> lo=14 hi=2; DIVU a=5 b=0 -> lo=FFFFFFFF hi=5 after the full 33 busy cycles.
- MTLO a=DEADBEEF in IDLE -> lo=DEADBEEF next cycle, hi unchanged, busy/stall stay 0. Then MULTU 3*4 with rd_req asserted on cycle 2 -> stall=1 until done; lo=0000000C.
- Second start (MTHI) during ITER -> stall=1, ignored until IDLE, then hi=a. Also check DIV 80000000/FFFFFFFF -> lo=80000000 hi=0.
- Drop reset low at ITER cycle 10 -> busy=0, hi=lo=0 asynchronously. After release, a fresh MULTU 2*3 completes with lo=6.
